// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, count enable and cascade outputs.
// Optional build macro MOD_UPDOWN_COUNTER_SATURATE_EN: saturate at the ends instead of wrapping.
module mod_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 10,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   // Everything is kept at WIDTH bits, so MODULUS == 2**WIDTH never needs a wider compare.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_load_err;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap_nxt;
   logic             w_err_nxt;
   logic             w_at_max;
   logic             w_at_min;

   assign w_at_max = (r_q == MAX_VAL);
   assign w_at_min = (r_q == ZERO);

   // Next-state selection: load has priority over counting; reset is applied in the register.
   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      w_err_nxt  = r_load_err;
      if (load) begin
         if (load_val <= MAX_VAL) begin
            w_q_nxt = load_val;
         end else begin
            w_q_nxt   = MAX_VAL;
            w_err_nxt = 1'b1;
         end
      end else if (en) begin
         if (up_dn) begin
            if (w_at_max) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
               w_q_nxt = r_q;
`else
               w_q_nxt    = ZERO;
               w_wrap_nxt = 1'b1;
`endif
            end else begin
               w_q_nxt = r_q + ONE;
            end
         end else begin
            if (w_at_min) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
               w_q_nxt = r_q;
`else
               w_q_nxt    = MAX_VAL;
               w_wrap_nxt = 1'b1;
`endif
            end else begin
               w_q_nxt = r_q - ONE;
            end
         end
      end else begin
         w_q_nxt = r_q;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q        <= RST_Q;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_q        <= w_q_nxt;
         r_wrap     <= w_wrap_nxt;
         r_load_err <= w_err_nxt;
      end
   end

   // tc is combinational so the next stage can use it directly as its enable.
   assign tc       = en & ((up_dn & w_at_max) | (~up_dn & w_at_min));
   assign q        = r_q;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomized and directed bench for mod_updown_counter against an arithmetic reference model.
module tb_mod_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // main DUT (WIDTH=4, MODULUS=10) and a natural-wrap DUT (WIDTH=3, MODULUS=8, RESET_VAL=5)
   logic       rst = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] q;
   logic       tc, wrap, load_err;
   logic [2:0] lv2 = 3'd0;
   logic [2:0] q2;
   logic       tc2, wrap2, err2;

   // cascade pair
   logic       c_rst = 1'b1, c_en = 1'b0;
   logic [3:0] lo_q, hi_q;
   logic       tc_lo, tc_hi, w_lo, w_hi, e_lo, e_hi;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .q(q), .tc(tc), .wrap(wrap), .load_err(load_err));

   mod_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) u_p2 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv2),
      .q(q2), .tc(tc2), .wrap(wrap2), .load_err(err2));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
      .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .q(lo_q), .tc(tc_lo), .wrap(w_lo), .load_err(e_lo));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
      .clk(clk), .rst(c_rst), .en(tc_lo), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .q(hi_q), .tc(tc_hi), .wrap(w_hi), .load_err(e_hi));

   // reference model state
   int m_q = 0, p_q = 5, cl_q = 0, ch_q = 0;
   bit m_w = 0, p_w = 0, cl_w = 0, ch_w = 0;
   bit m_e = 0, p_e = 0, cl_e = 0, ch_e = 0;

   task automatic mstep(input int md, input int rv, input bit r, input bit ld, input bit e,
                        input bit ud, input int lv, inout int mq, inout bit mw, inout bit me);
      if (r) begin
         mq = rv; mw = 1'b0; me = 1'b0;
      end else if (ld) begin
         mw = 1'b0;
         if (lv < md) mq = lv;
         else begin mq = md - 1; me = 1'b1; end
      end else if (e) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
         mw = 1'b0;
         if (ud && mq < md - 1) mq = mq + 1;
         else if (!ud && mq > 0) mq = mq - 1;
`else
         if (ud) begin mw = (mq + 1 >= md); mq = (mq + 1) % md; end
         else begin mw = (mq == 0); mq = (mq + md - 1) % md; end
`endif
      end else begin
         mw = 1'b0;
      end
   endtask

   task automatic tick();
      bit t_lo;
      @(posedge clk);
      t_lo = c_en && (cl_q == 9);
      mstep(10, 0, rst, load, en, up_dn, int'(load_val), m_q, m_w, m_e);
      mstep(8, 5, rst, load, en, up_dn, int'(lv2), p_q, p_w, p_e);
      mstep(10, 0, c_rst, 1'b0, c_en, 1'b1, 0, cl_q, cl_w, cl_e);
      mstep(10, 0, c_rst, 1'b0, t_lo, 1'b1, 0, ch_q, ch_w, ch_e);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; load = 1'b0;
      tick(); tick();
      n_vec++; if (q !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
         n_err++; $display("FAIL reset: q=%0d wrap=%b err=%b, want 0/0/0", q, wrap, load_err); end
      n_vec++; if (q2 !== 3'd5) begin
         n_err++; $display("FAIL reset_val: q2=%0d, want 5", q2); end
      rst = 1'b0;
   endtask

   task automatic test_count(input bit dir, input int cycles);
      rst = 1'b1; tick();
      rst = 1'b0; en = 1'b1; up_dn = dir; load = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         #1;
         n_vec++; if (tc !== (dir ? (m_q == 9) : (m_q == 0))) begin
            n_err++; $display("FAIL count_tc dir=%0b i=%0d: tc=%b at q=%0d", dir, i, tc, m_q); end
         tick();
         n_vec++; if (int'(q) !== m_q || wrap !== m_w) begin
            n_err++; $display("FAIL count dir=%0b i=%0d: q=%0d wrap=%b, want %0d/%b", dir, i, q, wrap, m_q, m_w); end
      end
   endtask

   task automatic reach(input int v);
      rst = 1'b1; load = 1'b0; tick();
      rst = 1'b0; en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < v; i++) tick();
   endtask

   task automatic test_load_priority();
      reach(3);
      load = 1'b1; load_val = 4'd7; en = 1'b1;
      tick();
      load = 1'b0; en = 1'b0;
      n_vec++; if (q !== 4'd7 || wrap !== 1'b0) begin
         n_err++; $display("FAIL load_priority: q=%0d wrap=%b, want 7/0", q, wrap); end
   endtask

   task automatic test_load_err();
      load = 1'b1; load_val = 4'd12; tick();
      n_vec++; if (q !== 4'd9 || load_err !== 1'b1) begin
         n_err++; $display("FAIL load_clamp: q=%0d err=%b, want 9/1", q, load_err); end
      load = 1'b0; en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      load = 1'b1; load_val = 4'd2; tick();
      load = 1'b0; en = 1'b0;
      n_vec++; if (q !== 4'd2 || load_err !== 1'b1) begin
         n_err++; $display("FAIL load_err_sticky: q=%0d err=%b, want 2/1", q, load_err); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_vec++; if (load_err !== 1'b0) begin
         n_err++; $display("FAIL load_err_clear: err=%b, want 0", load_err); end
   endtask

   task automatic test_simultaneous();
      reach(4);
      load = 1'b1; load_val = 4'd15; en = 1'b0; tick();   // set error flag, q=9
      load = 1'b1; load_val = 4'd5; tick();
      n_vec++; if (q !== 4'd5 || load_err !== 1'b1) begin
         n_err++; $display("FAIL simul_setup: q=%0d err=%b, want 5/1", q, load_err); end
      rst = 1'b1; load = 1'b1; load_val = 4'd4; en = 1'b1; tick();
      rst = 1'b0; load = 1'b0; en = 1'b0;
      n_vec++; if (q !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
         n_err++; $display("FAIL simul_rst: q=%0d wrap=%b err=%b, want 0/0/0", q, wrap, load_err); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 29) == 0);
         load     = ($urandom_range(0, 7) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up_dn    = ($urandom_range(0, 9) < 6);
         load_val = 4'($urandom_range(0, 15));
         lv2      = 3'($urandom_range(0, 7));
         #1;
         n_vec++; if (tc !== (en && (up_dn ? (m_q == 9) : (m_q == 0)))) begin
            n_err++; $display("FAIL rand_tc i=%0d: tc=%b q=%0d en=%b ud=%b", i, tc, m_q, en, up_dn); end
         n_vec++; if (tc2 !== (en && (up_dn ? (p_q == 7) : (p_q == 0)))) begin
            n_err++; $display("FAIL rand_tc2 i=%0d: tc2=%b q2=%0d", i, tc2, p_q); end
         tick();
         n_vec++; if (int'(q) !== m_q || wrap !== m_w || load_err !== m_e) begin
            n_err++; $display("FAIL rand i=%0d: q=%0d wrap=%b err=%b, want %0d/%b/%b", i, q, wrap, load_err, m_q, m_w, m_e); end
         n_vec++; if (int'(q2) !== p_q || wrap2 !== p_w || err2 !== p_e) begin
            n_err++; $display("FAIL rand2 i=%0d: q2=%0d wrap2=%b err2=%b, want %0d/%b/%b", i, q2, wrap2, err2, p_q, p_w, p_e); end
      end
      rst = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_cascade();
      int prev_lo, prev_hi;
      c_rst = 1'b1; c_en = 1'b0; tick(); tick();
      c_rst = 1'b0; c_en = 1'b1;
      for (int i = 0; i < 105; i++) begin
         prev_lo = int'(lo_q); prev_hi = int'(hi_q);
         tick();
         n_vec++; if (int'(lo_q) !== cl_q || int'(hi_q) !== ch_q) begin
            n_err++; $display("FAIL cascade i=%0d: hi=%0d lo=%0d, want %0d/%0d", i, hi_q, lo_q, ch_q, cl_q); end
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
         n_vec++; if ((int'(hi_q) != prev_hi) !== (prev_lo == 9 && lo_q == 4'd0)) begin
            n_err++; $display("FAIL cascade_carry i=%0d: hi %0d->%0d lo %0d->%0d", i, prev_hi, hi_q, prev_lo, lo_q); end
`endif
      end
      c_en = 1'b0;
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
      n_vec++; if (hi_q !== 4'd0 || lo_q !== 4'd5) begin
         n_err++; $display("FAIL cascade_final: hi=%0d lo=%0d, want 0/5", hi_q, lo_q); end
`endif
   endtask

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
   task automatic test_saturate();
      rst = 1'b1; tick();
      rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         n_vec++; if (wrap !== 1'b0) begin
            n_err++; $display("FAIL sat_wrap i=%0d: wrap=%b, want 0", i, wrap); end
      end
      n_vec++; if (q !== 4'd9 || tc !== 1'b1) begin
         n_err++; $display("FAIL sat_hold: q=%0d tc=%b, want 9/1", q, tc); end
      up_dn = 1'b0; tick();
      n_vec++; if (q !== 4'd8) begin
         n_err++; $display("FAIL sat_down: q=%0d, want 8", q); end
      en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_count(1'b1, 12);
      test_count(1'b0, 12);
      test_load_priority();
      test_load_err();
      test_simultaneous();
      test_random();
      test_cascade();
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      test_saturate();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
